sb_read_arbiter: RTL and testbench

Shares one AXI read-address channel and one read-data channel between NUM_CELLS stream-buffer cells. Requests are granted round-robin, the address is latched and held until ARREADY, and each granted cell is tagged with a unique ARID. Returning beats are routed back to the owning cell by RID. The block sits between the stream-buffer cell array and the memory-side AXI read interface.

---
 rtl/sb_read_arbiter_pkg.sv | 14 +
 rtl/sb_read_arbiter_if.sv | 30 +++
 rtl/sb_read_arbiter_rr_picker.sv | 29 ++
 rtl/sb_read_arbiter.sv | 139 +++++++++++++
 tb/tb_sb_read_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sb_read_arbiter_pkg.sv
// Shared types and helpers for the stream-buffer read arbiter:
// FSM state encoding and the cell-index to AXI ID mapping.
package sb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADDR = 1'b1
  } arb_state_e;

  function automatic int cell_to_id(input int id_base, input int cell_idx);
    return id_base + cell_idx;
  endfunction

endpackage

// File: rtl/sb_read_arbiter_if.sv
// Memory-side AXI read channels (AR + R) shared by all stream-buffer cells.
interface sb_read_arbiter_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  m_arvalid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [ID_WIDTH-1:0]   m_arid;
  logic                  m_arready;
  logic                  m_rvalid;
  logic                  m_rlast;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [ID_WIDTH-1:0]   m_rid;
  logic                  m_rready;

  // Arbiter side issues addresses and sinks read beats.
  modport master (
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    input  m_arready, m_rvalid, m_rlast, m_rdata, m_rid
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    output m_arready, m_rvalid, m_rlast, m_rdata, m_rid
  );

endinterface

// File: rtl/sb_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping modulo NUM_CELLS; returns one-hot grant and its index.
module rr_picker #(
  parameter int NUM_CELLS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CELLS-1:0] eligible,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CELLS-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset down so the nearest eligible cell wins.
  always_comb begin
    cand_s      = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = NUM_CELLS - 1; off >= 0; off--) begin
      cand_s      = IDX_W'((int'(rr_ptr) + off) % NUM_CELLS);
      grant_idx   = eligible[cand_s] ? cand_s : grant_idx;
      grant_valid = grant_valid | eligible[cand_s];
    end
    grant_onehot = grant_valid ? (NUM_CELLS'(1'b1) << grant_idx) : '0;
  end

endmodule

// File: rtl/sb_read_arbiter.sv
// Round-robin sharing of one AXI read address/data channel pair between
// NUM_CELLS stream-buffer cells; beats are routed back by RID.
module sb_read_arbiter
  import sb_arb_pkg::*;
#(
  parameter int NUM_CELLS  = 4,
  parameter int ID_BASE    = 0,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CELLS-1:0]                 cell_ar_valid,
  input  logic [NUM_CELLS-1:0][ADDR_WIDTH-1:0] cell_ar_addr,
  input  logic [NUM_CELLS-1:0][7:0]            cell_ar_len,
  output logic [NUM_CELLS-1:0]                 cell_ar_ready,
  output logic [NUM_CELLS-1:0]                 cell_r_valid,
  output logic                                 cell_r_last,
  output logic [DATA_WIDTH-1:0]                cell_r_data,
  sb_read_arbiter_if.master                    mem,
  output logic [NUM_CELLS-1:0]                 busy,
  output logic                                 rid_error
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  arb_state_e            state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      grant_idx_r;
  logic [NUM_CELLS-1:0]  busy_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [7:0]            arlen_r;
  logic [ID_WIDTH-1:0]   arid_r;
  logic                  rid_error_r;

  logic [NUM_CELLS-1:0]  eligible_s;
  logic [NUM_CELLS-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_valid_s;
  logic                  ar_hs_s;
  logic [NUM_CELLS-1:0]  ar_set_s;
  logic [NUM_CELLS-1:0]  id_match_s;
  logic [NUM_CELLS-1:0]  beat_s;
  logic [NUM_CELLS-1:0]  rlast_clr_s;
  logic                  beat_hit_s;

  // A cell with a burst in flight (including one retiring this cycle) cannot request.
  assign eligible_s = cell_ar_valid & ~busy_r;

  rr_picker #(
    .NUM_CELLS (NUM_CELLS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .eligible     (eligible_s),
    .rr_ptr       (rr_ptr_r),
    .grant_onehot (pick_onehot_s),
    .grant_idx    (pick_idx_s),
    .grant_valid  (pick_valid_s)
  );

  // Address handshake decode; the ready pulse goes to the latched grantee.
  always_comb begin
    ar_hs_s  = (state_r == ADDR) && mem.m_arready;
    ar_set_s = '0;
    if (ar_hs_s) begin
      ar_set_s = NUM_CELLS'(1'b1) << grant_idx_r;
    end else begin
      ar_set_s = '0;
    end
  end

  // RID decode: a beat only belongs to a cell that actually has a burst open.
  always_comb begin
    id_match_s = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      id_match_s[k] = (mem.m_rid == ID_WIDTH'(cell_to_id(ID_BASE, k)));
    end
    beat_s      = {NUM_CELLS{mem.m_rvalid}} & id_match_s & busy_r;
    beat_hit_s  = |beat_s;
    rlast_clr_s = beat_s & {NUM_CELLS{mem.m_rlast}};
  end

  // Address FSM, busy tracking and sticky RID error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      busy_r      <= '0;
      araddr_r    <= '0;
      arlen_r     <= 8'd0;
      arid_r      <= '0;
      rid_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            araddr_r    <= cell_ar_addr[pick_idx_s];
            arlen_r     <= cell_ar_len[pick_idx_s];
            arid_r      <= ID_WIDTH'(cell_to_id(ID_BASE, int'(pick_idx_s)));
            grant_idx_r <= pick_idx_s;
            state_r     <= ADDR;
          end else begin
            state_r     <= IDLE;
          end
        end
        ADDR: begin
          if (mem.m_arready) begin
            rr_ptr_r <= (grant_idx_r == IDX_W'(NUM_CELLS - 1)) ? '0
                                                               : grant_idx_r + IDX_W'(1);
            state_r  <= IDLE;
          end else begin
            state_r  <= ADDR;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      busy_r      <= (busy_r & ~rlast_clr_s) | ar_set_s;
      rid_error_r <= rid_error_r | (mem.m_rvalid & ~beat_hit_s);
    end
  end

  assign mem.m_arvalid = (state_r == ADDR);
  assign mem.m_araddr  = araddr_r;
  assign mem.m_arlen   = arlen_r;
  assign mem.m_arid    = arid_r;
  assign mem.m_rready  = 1'b1;

  assign cell_ar_ready = ar_set_s;
  assign cell_r_valid  = beat_s;
  assign cell_r_last   = mem.m_rlast;
  assign cell_r_data   = mem.m_rdata;
  assign busy          = busy_r;
  assign rid_error     = rid_error_r;

endmodule

// File: tb/tb_sb_read_arbiter.sv
// Directed self-checking bench for sb_read_arbiter (4 cells, ID_BASE 0).
module tb_sb_read_arbiter;

  localparam int N   = 4;
  localparam int IDB = 0;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         cell_ar_valid;
  logic [N-1:0][AW-1:0] cell_ar_addr;
  logic [N-1:0][7:0]    cell_ar_len;
  logic [N-1:0]         cell_ar_ready;
  logic [N-1:0]         cell_r_valid;
  logic                 cell_r_last;
  logic [DW-1:0]        cell_r_data;
  logic [N-1:0]         busy;
  logic                 rid_error;

  int checks = 0;
  int errors = 0;

  sb_read_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  sb_read_arbiter #(
    .NUM_CELLS (N), .ID_BASE (IDB), .ID_WIDTH (IDW), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cell_ar_valid (cell_ar_valid),
    .cell_ar_addr  (cell_ar_addr),
    .cell_ar_len   (cell_ar_len),
    .cell_ar_ready (cell_ar_ready),
    .cell_r_valid  (cell_r_valid),
    .cell_r_last   (cell_r_last),
    .cell_r_data   (cell_r_data),
    .mem           (mem),
    .busy          (busy),
    .rid_error     (rid_error)
  );

  always #5 clk = ~clk;

  task automatic drive_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cell_ar_valid = '0; cell_ar_addr = '0; cell_ar_len = '0;
    mem.m_arready = 1'b0; mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
    mem.m_rdata = '0; mem.m_rid = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem.m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", mem.m_arvalid); end
    checks++; if (busy !== 4'b0000 || rid_error !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got busy=%b err=%b expected 0000/0", busy, rid_error); end
    checks++; if (mem.m_araddr !== 32'h0 || mem.m_arid !== 4'h0 || mem.m_arlen !== 8'h0) begin errors++; $display("FAIL reset_addr: got %h/%h/%h expected zeros", mem.m_araddr, mem.m_arid, mem.m_arlen); end
    checks++; if (mem.m_rready !== 1'b1 || cell_ar_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got rready=%b arready=%b expected 1/0000", mem.m_rready, cell_ar_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    drive_edge();
    cell_ar_addr[2] = 32'h0000_1040; cell_ar_len[2] = 8'd4;
    cell_ar_valid = 4'b0100; mem.m_arready = 1'b1;
    @(negedge clk);
    checks++; if (mem.m_arvalid !== 1'b0) begin errors++; $display("FAIL single_idle_cycle: got arvalid=%b expected 0", mem.m_arvalid); end
    drive_edge();
    @(negedge clk);
    checks++; if (mem.m_arvalid !== 1'b1 || mem.m_araddr !== 32'h0000_1040 || mem.m_arlen !== 8'd4 || mem.m_arid !== 4'd2)
      begin errors++; $display("FAIL single_ar: got v=%b a=%h l=%0d id=%0d expected 1/00001040/4/2", mem.m_arvalid, mem.m_araddr, mem.m_arlen, mem.m_arid); end
    checks++; if (cell_ar_ready !== 4'b0100) begin errors++; $display("FAIL single_cell_ready: got %b expected 0100", cell_ar_ready); end
    drive_edge();
    cell_ar_valid = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 4'b0100 || cell_ar_ready !== 4'b0000 || mem.m_arvalid !== 1'b0)
      begin errors++; $display("FAIL single_busy: got busy=%b rdy=%b v=%b expected 0100/0000/0", busy, cell_ar_ready, mem.m_arvalid); end
    drive_edge();
    mem.m_rvalid = 1'b1; mem.m_rlast = 1'b1; mem.m_rid = 4'd2; mem.m_rdata = 32'hCAFE_0002;
    @(negedge clk);
    checks++; if (cell_r_valid !== 4'b0100 || cell_r_data !== 32'hCAFE_0002) begin errors++; $display("FAIL single_beat: got v=%b d=%h expected 0100/cafe0002", cell_r_valid, cell_r_data); end
    drive_edge();
    mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL single_retire: got busy=%b expected 0000", busy); end
  endtask

  task automatic test_backpressure;
    drive_edge();
    mem.m_arready = 1'b0;
    cell_ar_addr[1] = 32'h0000_2080; cell_ar_len[1] = 8'd7; cell_ar_valid = 4'b0010;
    drive_edge();
    cell_ar_valid = 4'b0000; cell_ar_addr[1] = 32'hFFFF_FFFF; cell_ar_len[1] = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (mem.m_arvalid !== 1'b1 || mem.m_araddr !== 32'h0000_2080 || mem.m_arlen !== 8'd7 || mem.m_arid !== 4'd1 || cell_ar_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b a=%h l=%0d id=%0d rdy=%b expected 1/00002080/7/1/0000", i, mem.m_arvalid, mem.m_araddr, mem.m_arlen, mem.m_arid, cell_ar_ready); end
      drive_edge();
    end
    mem.m_arready = 1'b1;
    @(negedge clk);
    checks++; if (cell_ar_ready !== 4'b0010) begin errors++; $display("FAIL bp_handshake: got %b expected 0010", cell_ar_ready); end
    drive_edge();
    @(negedge clk);
    checks++; if (busy !== 4'b0010 || mem.m_arvalid !== 1'b0) begin errors++; $display("FAIL bp_busy: got busy=%b v=%b expected 0010/0", busy, mem.m_arvalid); end
    drive_edge();
    mem.m_rvalid = 1'b1; mem.m_rlast = 1'b1; mem.m_rid = 4'd1;
    drive_edge();
    mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_oh;
    int g;
    pulse_reset();
    for (int c = 0; c < N; c++) begin
      cell_ar_addr[c] = 32'h0000_3000 + 32'(c) * 32'h100; cell_ar_len[c] = 8'd0;
    end
    cell_ar_valid = 4'b1111; mem.m_arready = 1'b1;
    drive_edge();
    for (int i = 0; i < 6; i++) begin
      g = i % N;
      exp_oh = 4'b0001 << g;
      @(negedge clk);
      checks++; if (cell_ar_ready !== exp_oh || mem.m_arid !== 4'(g) || mem.m_araddr !== 32'h0000_3000 + 32'(g) * 32'h100)
        begin errors++; $display("FAIL fair_grant%0d: got rdy=%b id=%0d a=%h expected %b/%0d", i, cell_ar_ready, mem.m_arid, mem.m_araddr, exp_oh, g); end
      drive_edge();
      mem.m_rvalid = 1'b1; mem.m_rlast = 1'b1; mem.m_rid = 4'(g);
      @(negedge clk);
      checks++; if (mem.m_arvalid !== 1'b0 || cell_r_valid !== exp_oh)
        begin errors++; $display("FAIL fair_gap%0d: got v=%b rv=%b expected 0/%b", i, mem.m_arvalid, cell_r_valid, exp_oh); end
      drive_edge();
      mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
    end
    cell_ar_valid = 4'b0000;
  endtask

  task automatic test_routing;
    pulse_reset();
    cell_ar_addr[3] = 32'h0000_4000; cell_ar_len[3] = 8'd3;
    cell_ar_valid = 4'b1000; mem.m_arready = 1'b1;
    drive_edge();
    @(negedge clk);
    checks++; if (cell_ar_ready !== 4'b1000 || mem.m_arid !== 4'd3) begin errors++; $display("FAIL route_grant: got rdy=%b id=%0d expected 1000/3", cell_ar_ready, mem.m_arid); end
    drive_edge();
    cell_ar_valid = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      mem.m_rvalid = 1'b1; mem.m_rid = 4'd3; mem.m_rdata = 32'hD000_0000 + 32'(b);
      mem.m_rlast = (b == 3);
      @(negedge clk);
      checks++; if (cell_r_valid !== 4'b1000 || cell_r_data !== 32'hD000_0000 + 32'(b) || cell_r_last !== (b == 3) || busy !== 4'b1000)
        begin errors++; $display("FAIL route_beat%0d: got rv=%b d=%h l=%b busy=%b expected 1000/%h/%b/1000", b, cell_r_valid, cell_r_data, cell_r_last, busy, 32'hD000_0000 + 32'(b), (b == 3)); end
      drive_edge();
    end
    mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 4'b0000 || rid_error !== 1'b0) begin errors++; $display("FAIL route_retire: got busy=%b err=%b expected 0000/0", busy, rid_error); end
  endtask

  task automatic test_error_reset;
    drive_edge();
    cell_ar_addr[0] = 32'h0000_5000; cell_ar_valid = 4'b0001; mem.m_arready = 1'b1;
    drive_edge();
    drive_edge();
    cell_ar_valid = 4'b0000;
    mem.m_rvalid = 1'b1; mem.m_rlast = 1'b1; mem.m_rid = 4'd7;
    @(negedge clk);
    checks++; if (cell_r_valid !== 4'b0000 || rid_error !== 1'b0 || busy !== 4'b0001)
      begin errors++; $display("FAIL err_drop: got rv=%b err=%b busy=%b expected 0000/0/0001", cell_r_valid, rid_error, busy); end
    drive_edge();
    mem.m_rvalid = 1'b0; mem.m_rlast = 1'b0;
    @(negedge clk);
    checks++; if (rid_error !== 1'b1 || busy !== 4'b0001) begin errors++; $display("FAIL err_set: got err=%b busy=%b expected 1/0001", rid_error, busy); end
    repeat (3) @(negedge clk);
    checks++; if (rid_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", rid_error); end
    drive_edge();
    mem.m_arready = 1'b0; cell_ar_addr[1] = 32'h0000_6000; cell_ar_valid = 4'b0010;
    drive_edge();
    @(negedge clk);
    checks++; if (mem.m_arvalid !== 1'b1 || mem.m_arid !== 4'd1) begin errors++; $display("FAIL err_addr_phase: got v=%b id=%0d expected 1/1", mem.m_arvalid, mem.m_arid); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (mem.m_arvalid !== 1'b0 || mem.m_araddr !== 32'h0 || mem.m_arid !== 4'h0)
      begin errors++; $display("FAIL rst_abort: got v=%b a=%h id=%0d expected 0/0/0", mem.m_arvalid, mem.m_araddr, mem.m_arid); end
    checks++; if (busy !== 4'b0000 || rid_error !== 1'b0) begin errors++; $display("FAIL rst_clear: got busy=%b err=%b expected 0000/0", busy, rid_error); end
    cell_ar_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem.m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_idle: got v=%b expected 0", mem.m_arvalid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fairness();
    test_routing();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
